mem_port_arbiter: RTL

Round-robin arbiter and sequencer that shares the single serial-wrapper memory port (1-bit data, 6-bit address, req/ready plus response-valid) between the per-core cache miss/writeback requesters of the multicore cache. It sits between the cores' memory-side request ports and the wrapper's memory interface. It serializes transactions, with one outstanding at a time, and routes read responses back to the granted core. It also detects memory timeouts and spurious responses.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int ADDR_W_DEF  = 6;
  localparam int TIMEOUT_DEF = 63;

  // Bit positions inside err_status.
  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_SPURIOUS = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after
// ptr_i, in ascending index order with wrap-around, wins.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int j;

  // Rotating priority search starting at the pointer.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr_i) + i) % N_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one serial memory port between N_REQ requesters: round-robin
// grant, one outstanding transaction, read-response routing, and sticky
// timeout / spurious-response flags.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int ADDR_W  = ADDR_W_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_rw,
  input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]             req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             resp_valid,
  output logic [N_REQ-1:0]             resp_data,
  output logic                         mem_req_valid,
  output logic                         mem_req_rw,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic                         mem_req_data,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic                         mem_resp_data,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         busy,
  output logic [1:0]                   err_status,
  input  logic                         err_clr
);

  localparam int CNT_W = 8;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    gid_q, gid_d;
  logic                mvld_q, mvld_d;
  logic                mrw_q, mrw_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                mdata_q, mdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    rvld_q, rvld_d;
  logic [N_REQ-1:0]    rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;

  logic [N_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // State and datapath registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      mvld_q   <= 1'b0;
      mrw_q    <= 1'b0;
      maddr_q  <= '0;
      mdata_q  <= 1'b0;
      cnt_q    <= '0;
      rvld_q   <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      mvld_q   <= mvld_d;
      mrw_q    <= mrw_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      cnt_q    <= cnt_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state, grant, response routing and error flag logic.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gid_d     = gid_q;
    mvld_d    = mvld_q;
    mrw_d     = mrw_q;
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    cnt_d     = cnt_q;
    rvld_d    = '0;
    rdata_d   = '0;
    req_ready = '0;
    // Clear first so a same-cycle error event below overrides it.
    err_d     = err_clr ? 2'b00 : err_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_gnt;
          gid_d     = arb_idx;
          mvld_d    = 1'b1;
          mrw_d     = req_rw[arb_idx];
          maddr_d   = req_addr[arb_idx];
          mdata_d   = req_data[arb_idx];
          state_d   = ISSUE;
        end
        if (mem_resp_valid) err_d[ERR_SPURIOUS] = 1'b1;
      end

      ISSUE: begin
        if (mem_req_ready) begin
          mvld_d   = 1'b0;
          rr_ptr_d = (gid_q == IDX_W'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
          if (mrw_q) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_RESP;
            cnt_d   = '0;
          end
        end
        if (mem_resp_valid) err_d[ERR_SPURIOUS] = 1'b1;
      end

      WAIT_RESP: begin
        if (mem_resp_valid) begin
          rvld_d[gid_q]  = 1'b1;
          rdata_d[gid_q] = mem_resp_data;
          state_d        = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // Forced completion: answer the core with zero data.
          rvld_d[gid_q]      = 1'b1;
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign resp_valid    = rvld_q;
  assign resp_data     = rdata_q;
  assign mem_req_valid = mvld_q;
  assign mem_req_rw    = mrw_q;
  assign mem_req_addr  = maddr_q;
  assign mem_req_data  = mdata_q;
  assign grant_id      = gid_q;
  assign busy          = (state_q != IDLE);
  assign err_status    = err_q;

endmodule
